// File: rtl/sram_uart_transmit_interface_pkg.sv
// Shared types for the SRAM <-> UART data paths: state encodings, bus widths and
// the saturating address increment used when walking SRAM.
package sram_uart_transmit_interface_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  // Receive path (UART -> SRAM write), kept beside the transmit states.
  typedef enum logic [2:0] {
    S_US_IDLE,
    S_US_RECEIVE_HI,
    S_US_RECEIVE_LO,
    S_US_WRITE
  } UART_SRAM_state_type;

  typedef enum logic [2:0] {
    S_SU_IDLE,
    S_SU_ISSUE,
    S_SU_WAIT,
    S_SU_SEND_HI,
    S_SU_WAIT_HI,
    S_SU_SEND_LO,
    S_SU_WAIT_LO,
    S_SU_NEXT
  } SRAM_UART_state_type;

  // The top word of SRAM is the last one; the address never wraps to 0.
  function automatic logic [ADDR_W-1:0] addr_sat_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_MAX) ? a : a + 1'b1;
  endfunction

endpackage

// File: rtl/sram_uart_transmit_interface_if.sv
// Control, SRAM read port and UART line of the SRAM-to-UART dump block.
// master = the dump block, slave = the surrounding system / SRAM controller.
interface sram_uart_transmit_interface_if;
  import sram_uart_transmit_interface_pkg::*;

  logic              Initialize;
  logic              Enable;
  logic [ADDR_W-1:0] Start_address;
  logic [ADDR_W-1:0] Word_count;
  logic [DATA_W-1:0] SRAM_read_data;
  logic [ADDR_W-1:0] SRAM_address;
  logic              SRAM_we_n;
  logic              UART_TX_O;
  logic              Busy;
  logic              Done;

  // Enable is a plain request: it is acted on only when sampled high while idle
  // (Busy low) and is otherwise ignored; there is no ready/acknowledge return.
  modport master (
    input  Initialize, Enable, Start_address, Word_count, SRAM_read_data,
    output SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done
  );

  modport slave (
    output Initialize, Enable, Start_address, Word_count, SRAM_read_data,
    input  SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done
  );

endinterface

// File: rtl/sram_uart_transmit_interface_uart_tx.sv
// 8N1 serializer: start bit, 8 data bits LSB first, stop bit, BAUD_DIV cycles each.
// Clear drops any byte in flight and returns the line high on the next cycle.
module uart_transmit_controller #(
  parameter int BAUD_DIV = 434
) (
  input  logic       Clock_50,
  input  logic       Resetn,
  input  logic       Clear,
  input  logic       Start,
  input  logic [7:0] TX_data,
  output logic       Busy,
  output logic       Done,
  output logic       UART_TX_O
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shift;

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      Busy      <= 1'b0;
      Done      <= 1'b0;
      UART_TX_O <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '1;
    end else begin
      Done <= 1'b0;
      if (Clear) begin
        Busy      <= 1'b0;
        UART_TX_O <= 1'b1;
        baud_cnt  <= '0;
        bit_cnt   <= '0;
        shift     <= '1;
      end else if (!Busy) begin
        if (Start) begin
          Busy      <= 1'b1;
          UART_TX_O <= 1'b0;
          shift     <= {1'b1, TX_data};
          bit_cnt   <= '0;
          baud_cnt  <= '0;
        end
      end else if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        // bit_cnt counts boundaries already passed; 9 means the stop bit just ended.
        if (bit_cnt == 4'd9) begin
          Busy      <= 1'b0;
          Done      <= 1'b1;
          UART_TX_O <= 1'b1;
        end else begin
          UART_TX_O <= shift[0];
          shift     <= {1'b1, shift[8:1]};
          bit_cnt   <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_uart_transmit_interface.sv
// Reads 16-bit SRAM words and streams them over UART, high byte first.
// Read-only SRAM master; the caller muxes SRAM ownership.
module sram_uart_transmit_interface
  import sram_uart_transmit_interface_pkg::*;
#(
  parameter int CLOCK_FREQ   = 50_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int READ_LATENCY = 2
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  sram_uart_transmit_interface_if.master bus,
  output SRAM_UART_state_type           dbg_state
);

  localparam int BAUD_DIV = CLOCK_FREQ / BAUD_RATE;
  localparam logic [3:0] LAT_LAST = 4'(READ_LATENCY - 1);

  SRAM_UART_state_type state, state_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [ADDR_W-1:0]   remaining, remaining_n;
  logic [DATA_W-1:0]   word, word_n;
  logic [3:0]          lat_cnt, lat_n;
  logic                busy, busy_n;
  logic                done, done_n;
  logic                zero_pending, zero_n;
  logic                tx_start, tx_busy, tx_done;
  logic [7:0]          tx_data;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= S_SU_IDLE;
      addr         <= '0;
      remaining    <= '0;
      word         <= '0;
      lat_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      zero_pending <= 1'b0;
    end else begin
      state        <= state_n;
      addr         <= addr_n;
      remaining    <= remaining_n;
      word         <= word_n;
      lat_cnt      <= lat_n;
      busy         <= busy_n;
      done         <= done_n;
      zero_pending <= zero_n;
    end
  end

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    remaining_n = remaining;
    word_n      = word;
    lat_n       = lat_cnt;
    busy_n      = busy;
    done_n      = 1'b0;
    zero_n      = 1'b0;
    tx_start    = 1'b0;
    tx_data     = word[15:8];
    if (bus.Initialize) begin
      state_n     = S_SU_IDLE;
      addr_n      = '0;
      remaining_n = '0;
      lat_n       = '0;
      busy_n      = 1'b0;
    end else begin
      case (state)
        S_SU_IDLE: begin
          // A zero-length dump still reports one Busy cycle followed by Done.
          if (zero_pending) begin
            done_n = 1'b1;
            busy_n = 1'b0;
          end else if (bus.Enable) begin
            addr_n      = bus.Start_address;
            remaining_n = bus.Word_count;
            busy_n      = 1'b1;
            if (bus.Word_count == '0) zero_n = 1'b1;
            else                      state_n = S_SU_ISSUE;
          end
        end
        S_SU_ISSUE: begin
          lat_n   = '0;
          state_n = S_SU_WAIT;
        end
        S_SU_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            word_n  = bus.SRAM_read_data;
            state_n = S_SU_SEND_HI;
          end else begin
            lat_n = lat_cnt + 4'd1;
          end
        end
        S_SU_SEND_HI: begin
          tx_data = word[15:8];
          if (!tx_busy) begin
            tx_start = 1'b1;
            state_n  = S_SU_WAIT_HI;
          end
        end
        S_SU_WAIT_HI: if (tx_done) state_n = S_SU_SEND_LO;
        S_SU_SEND_LO: begin
          tx_data = word[7:0];
          if (!tx_busy) begin
            tx_start = 1'b1;
            state_n  = S_SU_WAIT_LO;
          end
        end
        S_SU_WAIT_LO: if (tx_done) state_n = S_SU_NEXT;
        S_SU_NEXT: begin
          remaining_n = remaining - 1'b1;
          // Reaching the top word ends the dump even if words remain.
          if (remaining == 18'd1 || addr == ADDR_MAX) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = S_SU_IDLE;
          end else begin
            addr_n  = addr_sat_inc(addr);
            state_n = S_SU_ISSUE;
          end
        end
        default: state_n = S_SU_IDLE;
      endcase
    end
  end

  uart_transmit_controller #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_tx (
    .Clock_50  (Clock),
    .Resetn    (Resetn),
    .Clear     (bus.Initialize),
    .Start     (tx_start),
    .TX_data   (tx_data),
    .Busy      (tx_busy),
    .Done      (tx_done),
    .UART_TX_O (bus.UART_TX_O)
  );

  assign bus.SRAM_address = addr;
  assign bus.SRAM_we_n    = 1'b1;
  assign bus.Busy         = busy;
  assign bus.Done         = done;
  assign dbg_state        = state;

endmodule
